// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU plus an iterative shift-add multiplier.
// Results, flags and writeback control are captured in the E/M pipeline
// register. A MUL stalls upstream while it iterates over the bits of B.
module execute_stage #(
  parameter int WIDTH        = 8,
  parameter int ADDRESSWIDTH = 3,
  parameter int SHIFTBITS    = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    validE,
  input  logic [2:0]              aluOpE,
  input  logic                    useImmE,
  input  logic [WIDTH-1:0]        reg1ContentE,
  input  logic [WIDTH-1:0]        reg2ContentE,
  input  logic [WIDTH-1:0]        inmediateE,
  input  logic [ADDRESSWIDTH-1:0] writeAddressE,
  input  logic                    writeEnableE,
  input  logic                    flushE,
  output logic                    stallE,
  output logic [WIDTH-1:0]        resultM,
  output logic [ADDRESSWIDTH-1:0] writeAddressM,
  output logic                    writeEnableM,
  output logic                    validM,
  output logic [3:0]              flagsM,
  output logic                    o_dbg_busy
);

  // Handshake: stallE=1 means this stage cannot take a new instruction at the
  // next edge, so upstream must hold every E input stable; stallE=0 means the
  // instruction presented this cycle (if validE) is consumed at the edge.

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LSL = 3'b101;
  localparam logic [2:0] OP_LSR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam logic [SHIFTBITS-1:0] LAST_ITER = SHIFTBITS'(WIDTH - 1);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t                  r_state;
  logic [SHIFTBITS-1:0]    r_count;
  logic [WIDTH-1:0]        r_a;
  logic [WIDTH-1:0]        r_b;
  logic [2*WIDTH-1:0]      r_acc;
  logic [ADDRESSWIDTH-1:0] r_wa;
  logic                    r_we;

  logic [WIDTH-1:0]        w_opb;
  logic [WIDTH:0]          w_sum;
  logic [WIDTH:0]          w_diff;
  logic [WIDTH-1:0]        w_res;
  logic                    w_c;
  logic                    w_v;
  logic [2*WIDTH-1:0]      w_addend;
  logic [2*WIDTH-1:0]      w_acc_next;
  logic [WIDTH-1:0]        w_prod_lo;
  logic                    w_prod_hi_nz;

  assign o_dbg_busy = (r_state == S_BUSY);
  assign w_opb      = useImmE ? inmediateE : reg2ContentE;
  assign w_sum      = {1'b0, reg1ContentE} + {1'b0, w_opb};
  assign w_diff     = {1'b0, reg1ContentE} - {1'b0, w_opb};

  // One shift-add step: add A shifted by the current bit position if that bit of B is set.
  assign w_addend     = r_b[r_count] ? ({{WIDTH{1'b0}}, r_a} << r_count) : '0;
  assign w_acc_next   = r_acc + w_addend;
  assign w_prod_lo    = w_acc_next[WIDTH-1:0];
  assign w_prod_hi_nz = |w_acc_next[2*WIDTH-1:WIDTH];

  // Single-cycle ALU result and C/V flags for the instruction in execute.
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (aluOpE)
      OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (reg1ContentE[WIDTH-1] == w_opb[WIDTH-1]) &&
                (w_sum[WIDTH-1] != reg1ContentE[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_diff[WIDTH-1:0];
        w_c   = ~w_diff[WIDTH];
        w_v   = (reg1ContentE[WIDTH-1] != w_opb[WIDTH-1]) &&
                (w_diff[WIDTH-1] != reg1ContentE[WIDTH-1]);
      end
      OP_AND:  w_res = reg1ContentE & w_opb;
      OP_OR:   w_res = reg1ContentE | w_opb;
      OP_XOR:  w_res = reg1ContentE ^ w_opb;
      OP_LSL:  w_res = reg1ContentE << w_opb[SHIFTBITS-1:0];
      OP_LSR:  w_res = reg1ContentE >> w_opb[SHIFTBITS-1:0];
      default: w_res = '0;
    endcase
  end

  // Stall while a MUL is being accepted or still has iterations left after this one.
  always_comb begin
    stallE = 1'b0;
    if (!reset && !flushE) begin
      if (r_state == S_IDLE) stallE = validE && (aluOpE == OP_MUL);
      else                   stallE = (r_count != LAST_ITER);
    end
  end

  // FSM and E/M register: bubble by default, overwritten when an instruction completes.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_count       <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_acc         <= '0;
      r_wa          <= '0;
      r_we          <= 1'b0;
      resultM       <= '0;
      writeAddressM <= '0;
      writeEnableM  <= 1'b0;
      validM        <= 1'b0;
      flagsM        <= '0;
    end else begin
      resultM       <= '0;
      writeAddressM <= '0;
      writeEnableM  <= 1'b0;
      validM        <= 1'b0;
      flagsM        <= '0;
      if (flushE) begin
        r_state <= S_IDLE;
        r_count <= '0;
      end else if (r_state == S_IDLE) begin
        if (validE && (aluOpE == OP_MUL)) begin
          r_a     <= reg1ContentE;
          r_b     <= w_opb;
          r_wa    <= writeAddressE;
          r_we    <= writeEnableE;
          r_acc   <= '0;
          r_count <= '0;
          r_state <= S_BUSY;
        end else if (validE) begin
          resultM       <= w_res;
          writeAddressM <= writeAddressE;
          writeEnableM  <= writeEnableE;
          validM        <= 1'b1;
          flagsM        <= {w_res[WIDTH-1], (w_res == '0), w_c, w_v};
        end
      end else begin
        if (r_count == LAST_ITER) begin
          resultM       <= w_prod_lo;
          writeAddressM <= r_wa;
          writeEnableM  <= r_we;
          validM        <= 1'b1;
          flagsM        <= {w_prod_lo[WIDTH-1], (w_prod_lo == '0), w_prod_hi_nz, 1'b0};
          r_state       <= S_IDLE;
          r_count       <= '0;
        end else begin
          r_acc   <= w_acc_next;
          r_count <= r_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: ALU ops, MUL timing, back-to-back MUL,
// flush and reset during a multiply.
module tb_execute_stage;

  logic       clock = 1'b0;
  logic       reset;
  logic       validE;
  logic [2:0] aluOpE;
  logic       useImmE;
  logic [7:0] reg1ContentE;
  logic [7:0] reg2ContentE;
  logic [7:0] inmediateE;
  logic [2:0] writeAddressE;
  logic       writeEnableE;
  logic       flushE;
  logic       stallE;
  logic [7:0] resultM;
  logic [2:0] writeAddressM;
  logic       writeEnableM;
  logic       validM;
  logic [3:0] flagsM;
  logic       o_dbg_busy;

  int n_checks = 0;
  int n_pass   = 0;
  int stall_cycles;

  execute_stage #(.WIDTH(8), .ADDRESSWIDTH(3), .SHIFTBITS(3)) dut (
    .clock(clock), .reset(reset), .validE(validE), .aluOpE(aluOpE),
    .useImmE(useImmE), .reg1ContentE(reg1ContentE), .reg2ContentE(reg2ContentE),
    .inmediateE(inmediateE), .writeAddressE(writeAddressE),
    .writeEnableE(writeEnableE), .flushE(flushE), .stallE(stallE),
    .resultM(resultM), .writeAddressM(writeAddressM), .writeEnableM(writeEnableM),
    .validM(validM), .flagsM(flagsM), .o_dbg_busy(o_dbg_busy)
  );

  // Clock
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic imm,
                       input logic [7:0] a, input logic [7:0] b, input logic [7:0] im,
                       input logic [2:0] wa, input logic we);
    validE = v; aluOpE = op; useImmE = imm; reg1ContentE = a; reg2ContentE = b;
    inmediateE = im; writeAddressE = wa; writeEnableE = we;
    #1;
  endtask

  task automatic check_m(input string tag, input logic [7:0] res, input logic [3:0] fl,
                         input logic v, input logic [2:0] wa, input logic we);
    check({tag, "_result"}, 32'(resultM), 32'(res));
    check({tag, "_flags"},  32'(flagsM),  32'(fl));
    check({tag, "_validM"}, 32'(validM),  32'(v));
    check({tag, "_waddrM"}, 32'(writeAddressM), 32'(wa));
    check({tag, "_wenM"},   32'(writeEnableM),  32'(we));
  endtask

  initial begin
    reset = 1'b1; flushE = 1'b0;
    drive(1'b0, 3'b000, 1'b0, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0);
    tick(); tick();
    check_m("reset", 8'h00, 4'h0, 1'b0, 3'd0, 1'b0);
    check("reset_stall", 32'(stallE), 32'd0);
    check("reset_busy", 32'(o_dbg_busy), 32'd0);
    reset = 1'b0;

    // ADD 0x7F + 0x01 -> 0x80, N=1 V=1
    drive(1'b1, 3'b000, 1'b0, 8'h7F, 8'h01, 8'h00, 3'd1, 1'b1);
    check("add_stall", 32'(stallE), 32'd0);
    tick();
    check_m("add", 8'h80, 4'b1001, 1'b1, 3'd1, 1'b1);

    // SUB 5 - imm 5 -> 0, Z=1 C=1
    drive(1'b1, 3'b001, 1'b1, 8'h05, 8'hAA, 8'h05, 3'd3, 1'b1);
    check("sub_stall", 32'(stallE), 32'd0);
    tick();
    check_m("sub", 8'h00, 4'b0110, 1'b1, 3'd3, 1'b1);

    // LSL 0x81 by 1 -> 0x02
    drive(1'b1, 3'b101, 1'b0, 8'h81, 8'h01, 8'h00, 3'd2, 1'b1);
    tick();
    check_m("lsl", 8'h02, 4'b0000, 1'b1, 3'd2, 1'b1);

    // LSR 0x80 by imm 7 -> 0x01, write disabled
    drive(1'b1, 3'b110, 1'b1, 8'h80, 8'h00, 8'h07, 3'd4, 1'b0);
    tick();
    check_m("lsr", 8'h01, 4'b0000, 1'b1, 3'd4, 1'b0);

    // SUB 0x03 - 0x05 -> 0xFE, borrow so C=0, N=1
    drive(1'b1, 3'b001, 1'b0, 8'h03, 8'h05, 8'h00, 3'd5, 1'b1);
    tick();
    check_m("sub_borrow", 8'hFE, 4'b1000, 1'b1, 3'd5, 1'b1);

    // Idle cycle writes a bubble
    drive(1'b0, 3'b000, 1'b0, 8'h11, 8'h22, 8'h00, 3'd6, 1'b1);
    tick();
    check_m("bubble", 8'h00, 4'h0, 1'b0, 3'd0, 1'b0);

    // MUL 0x0D * 0x0B = 0x8F: stall 8 cycles, result at edge 9
    drive(1'b1, 3'b111, 1'b0, 8'h0D, 8'h0B, 8'h00, 3'd7, 1'b1);
    stall_cycles = 0;
    for (int e = 1; e <= 9; e++) begin
      if (stallE === 1'b1) stall_cycles++;
      tick();
      if (e < 9) check($sformatf("mul1_validM_e%0d", e), 32'(validM), 32'd0);
    end
    check("mul1_stall_cycles", 32'(stall_cycles), 32'd8);
    check_m("mul1", 8'h8F, 4'b1000, 1'b1, 3'd7, 1'b1);
    check("mul1_idle", 32'(o_dbg_busy), 32'd0);

    // MUL 0x20 * 0x10 = 0x200 -> low 0x00, C=1 Z=1; then ADD 1+1
    drive(1'b1, 3'b111, 1'b0, 8'h20, 8'h10, 8'h00, 3'd2, 1'b1);
    for (int e = 1; e <= 9; e++) begin
      if (e == 9) check("mul2_last_stall", 32'(stallE), 32'd0);
      tick();
    end
    check_m("mul2", 8'h00, 4'b0110, 1'b1, 3'd2, 1'b1);
    drive(1'b1, 3'b000, 1'b0, 8'h01, 8'h01, 8'h00, 3'd1, 1'b1);
    tick();
    check_m("mul2_add", 8'h02, 4'b0000, 1'b1, 3'd1, 1'b1);

    // MUL 0xFF * 0xFF flushed on BUSY cycle 3; then XOR 0xF0 ^ 0xFF
    drive(1'b1, 3'b111, 1'b0, 8'hFF, 8'hFF, 8'h00, 3'd3, 1'b1);
    tick();
    check("flush_busy", 32'(o_dbg_busy), 32'd1);
    tick(); tick();
    flushE = 1'b1;
    #1;
    check("flush_stall", 32'(stallE), 32'd0);
    tick();
    flushE = 1'b0;
    check_m("flush", 8'h00, 4'h0, 1'b0, 3'd0, 1'b0);
    check("flush_idle", 32'(o_dbg_busy), 32'd0);
    drive(1'b1, 3'b100, 1'b0, 8'hF0, 8'hFF, 8'h00, 3'd4, 1'b1);
    tick();
    check_m("flush_xor", 8'h0F, 4'b0000, 1'b1, 3'd4, 1'b1);

    // Back-to-back MUL 0x03 * 0x05 = 0x0F
    drive(1'b1, 3'b111, 1'b1, 8'h03, 8'h00, 8'h05, 3'd6, 1'b0);
    for (int e = 1; e <= 9; e++) tick();
    check_m("mul3", 8'h0F, 4'b0000, 1'b1, 3'd6, 1'b0);

    // Reset during BUSY cycle 5 of a MUL, then an ADD completes normally
    drive(1'b1, 3'b111, 1'b0, 8'h12, 8'h34, 8'h00, 3'd5, 1'b1);
    for (int e = 1; e <= 5; e++) tick();
    check("rst_mid_busy", 32'(o_dbg_busy), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_stall", 32'(stallE), 32'd0);
    tick();
    check_m("rst_mid", 8'h00, 4'h0, 1'b0, 3'd0, 1'b0);
    check("rst_mid_idle", 32'(o_dbg_busy), 32'd0);
    reset = 1'b0;
    drive(1'b1, 3'b000, 1'b0, 8'h10, 8'h22, 8'h00, 3'd2, 1'b1);
    tick();
    check_m("rst_add", 8'h32, 4'b0000, 1'b1, 3'd2, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
